control_unit: RTL

//  Hardwired control sequencer for the datapath: the driver side of the control-signal interface

---
 rtl/control_pkg.sv | 70 +++++++
 rtl/control_unit_decode.sv | 122 ++++++++++++
 rtl/control_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared types and constants for the hardwired control sequencer:
// opcodes, ALU codes, T-state encoding and the packed control-signal bundle.
package control_pkg;

  localparam int OPC_W = 5;
  localparam int ALU_W = 5;

  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_ANDI = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_ORI  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_BR   = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_JR   = 5'b10011;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_ADD = 5'b00001;
  localparam logic [ALU_W-1:0] ALU_SUB = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_AND = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'b00100;

  typedef enum logic [3:0] {
    RST_S,
    T0, T1, T2, T3, T4, T5, T6, T7,
    HALT_S
  } state_t;

  typedef struct packed {
    logic             pc_enable;
    logic             pc_increment_enable;
    logic             ir_enable;
    logic             y_enable;
    logic             z_enable;
    logic             mar_enable;
    logic             mdr_enable;
    logic             r_enable;
    logic             con_enable;
    logic             read;
    logic             write;
    logic             gra;
    logic             grb;
    logic             baout;
    logic             pc_select;
    logic             z_lo_select;
    logic             mdr_select;
    logic             c_select;
    logic             r_select;
    logic [ALU_W-1:0] alu_instruction;
    logic             run;
  } ctrl_t;

  // Opcodes that continue past fetch into T3; NOP, HALT and unknown codes do not.
  function automatic logic has_exec(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_LD, OPC_LDI, OPC_ST, OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_BR, OPC_JR: has_exec = 1'b1;
      default:                                                              has_exec = 1'b0;
    endcase
  endfunction

  // Register-writing immediate forms finish at T5.
  function automatic logic ends_at_t5(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_LDI, OPC_ADDI, OPC_ANDI, OPC_ORI: ends_at_t5 = 1'b1;
      default:                              ends_at_t5 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational Moore decode: (T-state, opcode, CON flag) -> full control-signal bundle.
module control_unit_decode
  import control_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             con_output,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl     = '0;
    ctrl.run = (state != RST_S) && (state != HALT_S);
    case (state)
      T0: begin
        ctrl.pc_select  = 1'b1;
        ctrl.mar_enable = 1'b1;
      end
      T1: begin
        ctrl.pc_increment_enable = 1'b1;
        ctrl.read                = 1'b1;
        ctrl.mdr_enable          = 1'b1;
      end
      T2: begin
        ctrl.mdr_select = 1'b1;
        ctrl.ir_enable  = 1'b1;
      end
      T3: begin
        case (opcode)
          OPC_LDI, OPC_LD, OPC_ST: begin
            ctrl.grb      = 1'b1;
            ctrl.baout    = 1'b1;
            ctrl.y_enable = 1'b1;
          end
          OPC_ADDI, OPC_ANDI, OPC_ORI: begin
            ctrl.grb      = 1'b1;
            ctrl.r_select = 1'b1;
            ctrl.y_enable = 1'b1;
          end
          OPC_BR: begin
            ctrl.gra        = 1'b1;
            ctrl.r_select   = 1'b1;
            ctrl.con_enable = 1'b1;
          end
          OPC_JR: begin
            ctrl.gra       = 1'b1;
            ctrl.r_select  = 1'b1;
            ctrl.pc_enable = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (opcode)
          OPC_LDI, OPC_LD, OPC_ST, OPC_ADDI, OPC_ANDI, OPC_ORI: begin
            ctrl.c_select = 1'b1;
            ctrl.z_enable = 1'b1;
            if (opcode == OPC_ANDI)     ctrl.alu_instruction = ALU_AND;
            else if (opcode == OPC_ORI) ctrl.alu_instruction = ALU_OR;
            else                        ctrl.alu_instruction = ALU_ADD;
          end
          OPC_BR: begin
            ctrl.pc_select = 1'b1;
            ctrl.y_enable  = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OPC_LDI, OPC_ADDI, OPC_ANDI, OPC_ORI: begin
            ctrl.z_lo_select = 1'b1;
            ctrl.gra         = 1'b1;
            ctrl.r_enable    = 1'b1;
          end
          OPC_LD, OPC_ST: begin
            ctrl.z_lo_select = 1'b1;
            ctrl.mar_enable  = 1'b1;
          end
          OPC_BR: begin
            ctrl.c_select        = 1'b1;
            ctrl.alu_instruction = ALU_ADD;
            ctrl.z_enable        = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (opcode)
          OPC_LD: begin
            ctrl.read       = 1'b1;
            ctrl.mdr_enable = 1'b1;
          end
          OPC_ST: begin
            ctrl.gra        = 1'b1;
            ctrl.r_select   = 1'b1;
            ctrl.mdr_enable = 1'b1;
          end
          OPC_BR: begin
            // Branch target only reaches PC when the latched condition holds.
            ctrl.z_lo_select = con_output;
            ctrl.pc_enable   = con_output;
          end
          default: ;
        endcase
      end
      T7: begin
        case (opcode)
          OPC_LD: begin
            ctrl.mdr_select = 1'b1;
            ctrl.gra        = 1'b1;
            ctrl.r_enable   = 1'b1;
          end
          OPC_ST: ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: T-state register and next-state logic; outputs come
// from control_unit_decode as a pure function of the registered state.
module control_unit
  import control_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      IR_Data,
  input  logic             con_output,
  output logic             PC_enable,
  output logic             PC_increment_enable,
  output logic             IR_enable,
  output logic             Y_enable,
  output logic             Z_enable,
  output logic             MAR_enable,
  output logic             MDR_enable,
  output logic             r_enable,
  output logic             con_enable,
  output logic             read,
  output logic             write,
  output logic             Gra,
  output logic             Grb,
  output logic             BAout,
  output logic             PC_select,
  output logic             Z_LO_select,
  output logic             MDR_select,
  output logic             c_select,
  output logic             r_select,
  output logic [ALU_W-1:0] alu_instruction,
  output logic             run
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opcode;
  ctrl_t            ctrl;
  logic             ir_operand_unused;

  assign opcode            = IR_Data[31:27];
  assign ir_operand_unused = ^IR_Data[26:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RST_S;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_S: state_d = T0;
      T0:    state_d = T1;
      T1:    state_d = T2;
      T2: begin
        if (opcode == OPC_HALT)  state_d = HALT_S;
        else if (has_exec(opcode)) state_d = T3;
        else                     state_d = T0;
      end
      T3:     state_d = (opcode == OPC_JR) ? T0 : T4;
      T4:     state_d = T5;
      T5:     state_d = ends_at_t5(opcode) ? T0 : T6;
      T6:     state_d = (opcode == OPC_BR) ? T0 : T7;
      T7:     state_d = T0;
      HALT_S: state_d = HALT_S;
      default: state_d = RST_S;
    endcase
  end

  control_unit_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .con_output (con_output),
    .ctrl       (ctrl)
  );

  assign PC_enable           = ctrl.pc_enable;
  assign PC_increment_enable = ctrl.pc_increment_enable;
  assign IR_enable           = ctrl.ir_enable;
  assign Y_enable            = ctrl.y_enable;
  assign Z_enable            = ctrl.z_enable;
  assign MAR_enable          = ctrl.mar_enable;
  assign MDR_enable          = ctrl.mdr_enable;
  assign r_enable            = ctrl.r_enable;
  assign con_enable          = ctrl.con_enable;
  assign read                = ctrl.read;
  assign write               = ctrl.write;
  assign Gra                 = ctrl.gra;
  assign Grb                 = ctrl.grb;
  assign BAout               = ctrl.baout;
  assign PC_select           = ctrl.pc_select;
  assign Z_LO_select         = ctrl.z_lo_select;
  assign MDR_select          = ctrl.mdr_select;
  assign c_select            = ctrl.c_select;
  assign r_select            = ctrl.r_select;
  assign alu_instruction     = ctrl.alu_instruction;
  assign run                 = ctrl.run;

endmodule
